// File: rtl/mm_bus_pkg.sv
// Shared types and helpers for the memory-mapped I/O bridge.
package mm_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

  // Extracts the top sel_w bits of an addr_w-wide address (zero-extended to 8 bits).
  function automatic logic [7:0] region_of(input logic [31:0] a, input int addr_w, input int sel_w);
    logic [31:0] shifted;
    logic [31:0] mask;
    shifted = a >> (addr_w - sel_w);
    mask    = (32'd1 << sel_w) - 32'd1;
    return 8'(shifted & mask);
  endfunction

endpackage

// File: rtl/mm_addr_decode.sv
// Region field to one-hot slave select; region 0 and regions above NUM_SLV are not mapped.
module mm_addr_decode #(
  parameter int SEL_W   = 3,
  parameter int NUM_SLV = 4
) (
  input  logic [SEL_W-1:0]   region,
  output logic [NUM_SLV-1:0] sel,
  output logic               valid,
  output logic [SEL_W-1:0]   slot
);

  always_comb begin
    sel   = '0;
    valid = (region != '0) && (int'(region) <= NUM_SLV);
    slot  = region - SEL_W'(1);
    for (int i = 0; i < NUM_SLV; i++) begin
      if (valid && (region == SEL_W'(i + 1))) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/mm_bus_bridge.sv
// CPU external-port bridge: one slave access at a time, wait states via per-slave ready,
// timeout and unmapped-region errors reported through a sticky flag.
module mm_bus_bridge
  import mm_bus_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                SEL_W    = 3,
  parameter int                NUM_SLV  = 4,
  parameter int                TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mm_re,
  input  logic                      mm_we,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata,
  output logic                      stall,
  output logic                      bus_err,
  output logic [SEL_W-1:0]          err_slot,
  input  logic                      err_clr,
  output logic [NUM_SLV-1:0]        s_sel,
  output logic                      s_re,
  output logic                      s_we,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]        s_rdy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SEL_W-1:0]   slot_q;
  logic [SEL_W-1:0]   cur_region;

  logic [SEL_W-1:0]   region;
  logic [NUM_SLV-1:0] dec_sel;
  logic               dec_valid;
  logic [SEL_W-1:0]   dec_slot;
  logic               req;
  logic               launch;
  logic               rdy_hit;
  logic [DATA_W-1:0]  rd_mux;
  logic               timed_out;
  logic               err_evt;
  logic [SEL_W-1:0]   err_region;

  assign region = SEL_W'(region_of(32'(addr), ADDR_W, SEL_W));

  mm_addr_decode #(
    .SEL_W   (SEL_W),
    .NUM_SLV (NUM_SLV)
  ) u_decode (
    .region (region),
    .sel    (dec_sel),
    .valid  (dec_valid),
    .slot   (dec_slot)
  );

  assign req    = (mm_re | mm_we) && (region != '0);
  assign launch = dec_valid && (mm_re ^ mm_we);
  assign stall  = (state == ACCESS) || ((state == IDLE) && req);

  // Only the latched slot's ready and data are looked at; other slaves' ready is ignored.
  always_comb begin
    rdy_hit = 1'b0;
    rd_mux  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (slot_q == SEL_W'(i)) begin
        rdy_hit = s_rdy[i];
        rd_mux  = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign timed_out  = (state == ACCESS) && !rdy_hit && (cnt == CNT_W'(TIMEOUT));
  assign err_evt    = ((state == IDLE) && req && !launch) || timed_out;
  assign err_region = (state == IDLE) ? region : cur_region;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      slot_q     <= '0;
      cur_region <= '0;
      rdata      <= '0;
      s_sel      <= '0;
      s_re       <= 1'b0;
      s_we       <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          rdata <= '0;
          if (req && launch) begin
            state      <= ACCESS;
            cnt        <= '0;
            slot_q     <= dec_slot;
            cur_region <= region;
            s_sel      <= dec_sel;
            s_re       <= mm_re;
            s_we       <= mm_we;
            s_addr     <= addr;
            s_wdata    <= wdata;
          end else if (req) begin
            state <= ERR;
            rdata <= ERR_DATA;
          end
        end
        ACCESS: begin
          if (rdy_hit) begin
            state <= DONE;
            rdata <= s_re ? rd_mux : '0;
            s_sel <= '0;
            s_re  <= 1'b0;
            s_we  <= 1'b0;
          end else if (timed_out) begin
            state <= ERR;
            rdata <= ERR_DATA;
            s_sel <= '0;
            s_re  <= 1'b0;
            s_we  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          rdata <= '0;
        end
        ERR: begin
          state <= IDLE;
          rdata <= '0;
        end
        default: begin
          state <= IDLE;
          rdata <= '0;
        end
      endcase
    end
  end

  // A clear in the same cycle as a new error is applied first, so the new error is recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err  <= 1'b0;
      err_slot <= '0;
    end else if (err_evt) begin
      bus_err <= 1'b1;
      if (!bus_err || err_clr) err_slot <= err_region;
    end else if (err_clr) begin
      bus_err  <= 1'b0;
      err_slot <= '0;
    end
  end

endmodule

// File: tb/tb_mm_bus_bridge.sv
// Directed bench for mm_bus_bridge with a small wait-state slave model.
module tb_mm_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mm_re, mm_we;
  logic [15:0] addr, wdata, rdata;
  logic        stall, bus_err, err_clr;
  logic [2:0]  err_slot;
  logic [3:0]  s_sel;
  logic        s_re, s_we;
  logic [15:0] s_addr, s_wdata;
  logic [63:0] s_rdata;
  logic [3:0]  s_rdy;

  int checks = 0;
  int errors = 0;

  int         slv_wait [4];
  int         wcnt [4];
  logic [3:0] rdy_noise;

  int          n_stall, re_cnt, we_cnt;
  logic        stall_req, addr_ok, wdata_ok, end_stb, end_err;
  logic [3:0]  sel_seen, end_sel;
  logic [15:0] rd_end;
  logic [2:0]  end_slot;

  always #5 clk = ~clk;

  assign s_rdata = {16'h0F0F, 16'h9ABC, 16'h5678, 16'h1234};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) wcnt[i] <= s_sel[i] ? wcnt[i] + 1 : 0;
  end

  always_comb begin
    s_rdy = rdy_noise;
    for (int i = 0; i < 4; i++) begin
      if (s_sel[i] && (wcnt[i] == slv_wait[i])) s_rdy[i] = 1'b1;
    end
  end

  mm_bus_bridge dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mm_re    (mm_re),
    .mm_we    (mm_we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .bus_err  (bus_err),
    .err_slot (err_slot),
    .err_clr  (err_clr),
    .s_sel    (s_sel),
    .s_re     (s_re),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_rdy    (s_rdy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts at #1 after a rising edge in IDLE; returns #1 after the edge leaving DONE/ERR.
  task automatic access(input logic re, input logic we, input logic [15:0] a,
                        input logic [15:0] d, input bit hold);
    mm_re = re; mm_we = we; addr = a; wdata = d;
    @(negedge clk);
    stall_req = stall;
    @(posedge clk); #1;
    if (!hold) begin mm_re = 1'b0; mm_we = 1'b0; end
    err_clr = 1'b0;
    n_stall = 0; re_cnt = 0; we_cnt = 0; sel_seen = '0;
    addr_ok = 1'b1; wdata_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall) break;
      n_stall++;
      sel_seen |= s_sel;
      if (s_re) re_cnt++;
      if (s_we) we_cnt++;
      if (s_addr !== a) addr_ok = 1'b0;
      if (s_wdata !== d) wdata_ok = 1'b0;
    end
    rd_end   = rdata;
    end_sel  = s_sel;
    end_stb  = s_re | s_we;
    end_err  = bus_err;
    end_slot = err_slot;
    @(posedge clk); #1;
    mm_re = 1'b0; mm_we = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("clr_bus_err", 32'(bus_err), 32'd0);
    check("clr_err_slot", 32'(err_slot), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mm_re = 1'b0; mm_we = 1'b0; addr = '0; wdata = '0; err_clr = 1'b0;
    rdy_noise = '0;
    for (int i = 0; i < 4; i++) slv_wait[i] = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_ctrl", 32'({s_sel, s_re, s_we, bus_err, err_slot}), 32'd0);
    check("rst_s_addr", 32'(s_addr), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // read region 1, two wait states
    slv_wait[0] = 2;
    access(1'b1, 1'b0, 16'h2004, 16'h0000, 1'b0);
    check("t1_stall_req", 32'(stall_req), 32'd1);
    check("t1_stall_cycles", 32'(n_stall), 32'd3);
    check("t1_rdata", 32'(rd_end), 32'h1234);
    check("t1_s_addr_stable", 32'(addr_ok), 32'd1);
    check("t1_sel", 32'(sel_seen), 32'b0001);
    check("t1_re_cycles", 32'(re_cnt), 32'd3);
    check("t1_we_cycles", 32'(we_cnt), 32'd0);
    check("t1_done_sel", 32'(end_sel), 32'd0);
    @(negedge clk);
    check("t1_rdata_idle", 32'(rdata), 32'd0);
    @(posedge clk); #1;

    // write region 3, zero-wait; request held through DONE must not relaunch
    slv_wait[2] = 0;
    access(1'b0, 1'b1, 16'h6010, 16'hBEEF, 1'b1);
    check("t2_stall_cycles", 32'(n_stall), 32'd1);
    check("t2_sel", 32'(sel_seen), 32'b0100);
    check("t2_we_cycles", 32'(we_cnt), 32'd1);
    check("t2_re_cycles", 32'(re_cnt), 32'd0);
    check("t2_s_wdata", 32'(wdata_ok), 32'd1);
    check("t2_rdata_write", 32'(rd_end), 32'd0);
    @(negedge clk);
    check("t2_no_relaunch_stall", 32'(stall), 32'd0);
    check("t2_no_relaunch_we", 32'(s_we), 32'd0);
    @(posedge clk); #1;

    // read region 2, slave never ready; other slaves' ready must be ignored
    slv_wait[1] = -1;
    rdy_noise = 4'b1101;
    access(1'b1, 1'b0, 16'h4000, 16'h0000, 1'b0);
    rdy_noise = '0;
    check("t3_stall_cycles", 32'(n_stall), 32'd16);
    check("t3_rdata", 32'(rd_end), 32'hDEAD);
    check("t3_strobes", 32'({end_sel, end_stb}), 32'd0);
    check("t3_bus_err", 32'(end_err), 32'd1);
    check("t3_err_slot", 32'(end_slot), 32'd2);

    // unmapped region 7 after clearing, then sticky second error, then clear with new error
    pulse_clr();
    access(1'b1, 1'b0, 16'hE000, 16'h0000, 1'b0);
    check("t4_stall_req", 32'(stall_req), 32'd1);
    check("t4_stall_cycles", 32'(n_stall), 32'd0);
    check("t4_sel", 32'(end_sel), 32'd0);
    check("t4_rdata", 32'(rd_end), 32'hDEAD);
    check("t4_err_slot", 32'(end_slot), 32'd7);
    access(1'b0, 1'b1, 16'hA000, 16'h1111, 1'b0);
    check("t4_sticky_err", 32'(end_err), 32'd1);
    check("t4_sticky_slot", 32'(end_slot), 32'd7);
    err_clr = 1'b1;
    access(1'b1, 1'b0, 16'hC000, 16'h0000, 1'b0);
    check("t4_clr_vs_err_flag", 32'(end_err), 32'd1);
    check("t4_clr_vs_err_slot", 32'(end_slot), 32'd6);
    pulse_clr();

    // read and write together at region 1
    access(1'b1, 1'b1, 16'h2000, 16'h2222, 1'b0);
    check("t5_stall_cycles", 32'(n_stall), 32'd0);
    check("t5_strobes", 32'(re_cnt + we_cnt), 32'd0);
    check("t5_bus_err", 32'(end_err), 32'd1);
    check("t5_err_slot", 32'(end_slot), 32'd1);
    check("t5_rdata", 32'(rd_end), 32'hDEAD);

    // region 0 belongs to internal memory
    mm_re = 1'b1; addr = 16'h0100;
    @(negedge clk);
    check("t6_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 mm_re = 1'b0;
    @(negedge clk);
    check("t6_idle", 32'({stall, s_sel, s_re, rdata}), 32'd0);
    @(posedge clk); #1;

    // reset in the second access cycle
    slv_wait[0] = -1;
    mm_re = 1'b1; addr = 16'h2008;
    @(posedge clk); #1 mm_re = 1'b0;
    @(posedge clk); #1;
    check("t7_in_access", 32'(s_re), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_ctrl", 32'({stall, s_sel, s_re, s_we, bus_err, err_slot}), 32'd0);
    check("t7_rst_data", 32'({rdata, s_addr}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    slv_wait[3] = 0;
    access(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b0);
    check("t7_after_stall", 32'(n_stall), 32'd1);
    check("t7_after_rdata", 32'(rd_end), 32'h0F0F);
    check("t7_after_sel", 32'(sel_seen), 32'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
